// File: rtl/layer_ser_pkg.sv
// layer_ser_pkg: shared FSM state type and index-width helper for layer_serializer.
package layer_ser_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_serializer.sv
// layer_serializer: captures NN parallel neuron outputs and streams them one word per handshake.
// Optional feature: define LAYER_SER_OVERRUN_DET_EN to add the sticky overrun output.
module layer_serializer
    import layer_ser_pkg::*;
#(
    parameter int NN        = 10,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    o_data,
    input  logic                    o_ready,
    output logic                    o_last,
`ifdef LAYER_SER_OVERRUN_DET_EN
    output logic                    overrun,
`endif
    output logic                    busy
);

    localparam int IW = idx_width(NN);

    state_t               state, state_nxt;
    logic [IW-1:0]        idx;
    logic [dataWidth-1:0] hold [NN];
    logic                 xfer, wrap, cap;
    logic                 unused_valid;

    // Only neuron 0's valid starts a frame; the rest of the vector is deliberately ignored.
    assign unused_valid = ^i_valid;

    // Outputs and next state; a capture is allowed from IDLE or on the final transfer of a frame.
    always_comb begin
        o_valid   = (state == SHIFT);
        busy      = o_valid;
        o_last    = o_valid && (idx == IW'(NN - 1));
        o_data    = o_valid ? hold[idx] : '0;
        xfer      = o_valid && o_ready;
        wrap      = xfer && o_last;
        cap       = i_valid[0] && (!o_valid || wrap);
        state_nxt = cap ? SHIFT : wrap ? IDLE : state;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Holding register loads on capture; index walks the frame one step per accepted word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
            for (int k = 0; k < NN; k++) hold[k] <= '0;
        end else if (cap) begin
            idx <= '0;
            for (int k = 0; k < NN; k++) hold[k] <= i_data[k*dataWidth +: dataWidth];
        end else if (xfer && !o_last) begin
            idx <= idx + IW'(1);
        end
    end

`ifdef LAYER_SER_OVERRUN_DET_EN
    // Sticky flag for a start pulse that arrived while a frame was still streaming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              overrun <= 1'b0;
        else if (i_valid[0] && o_valid && !wrap) overrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: randomized and directed checks of layer_serializer against a word-queue model.
module tb_layer_serializer;

    localparam int NN = 10;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NN-1:0]     i_valid = '0;
    logic [NN*DW-1:0]  i_data = '0;
    logic              o_ready = 1'b0;
    logic              o_valid, o_last, busy;
    logic [DW-1:0]     o_data;
`ifdef LAYER_SER_OVERRUN_DET_EN
    logic              overrun;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: words still owed to the downstream side, oldest first.
    logic [DW-1:0] q[$];
    logic          exp_ovr = 1'b0;

    always #5 clk = ~clk;

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_valid(o_valid),
        .o_data(o_data),
        .o_ready(o_ready),
        .o_last(o_last),
`ifdef LAYER_SER_OVERRUN_DET_EN
        .overrun(overrun),
`endif
        .busy(busy)
    );

    function automatic logic [NN*DW-1:0] frame(input logic [DW-1:0] base);
        logic [NN*DW-1:0] f;
        for (int k = 0; k < NN; k++) f[k*DW +: DW] = base + DW'(k);
        return f;
    endfunction

    // Expected {o_valid, o_last, busy, o_data}: the model only ever holds one frame's remainder.
    function automatic logic [DW+2:0] exp_vec();
        logic ne;
        ne = (q.size() != 0);
        return {ne, q.size() == 1, ne, ne ? q[0] : DW'(0)};
    endfunction

    // Apply inputs at the falling edge, advance the model, move to the next falling edge.
    task automatic drive(input logic [NN-1:0] iv, input logic [NN*DW-1:0] d, input logic rdy);
        logic xfer, cap;
        i_valid = iv;
        i_data  = d;
        o_ready = rdy;
        xfer = (q.size() != 0) && rdy;
        cap  = iv[0] && (q.size() == 0 || (q.size() == 1 && rdy));
        if (iv[0] && !cap) exp_ovr = 1'b1;
        if (xfer) void'(q.pop_front());
        if (cap) for (int k = 0; k < NN; k++) q.push_back(d[k*DW +: DW]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        i_valid = '1;
        i_data  = frame(16'h0777);
        o_ready = 1'b1;
        #1;
        total++;
        if ({o_valid, o_last, busy, o_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {o_valid, o_last, busy, o_data});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({o_valid, o_last, busy, o_data} !== exp_vec()) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", {o_valid, o_last, busy, o_data}, exp_vec());
        end
`ifdef LAYER_SER_OVERRUN_DET_EN
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_overrun got=%b exp=0", overrun);
        end
`endif
    endtask

    task automatic test_basic();
        int nv = 0;
        drive('1, frame(16'h0100), 1'b1);
        for (int n = 1; n <= 11; n++) begin
            total++;
            if ({o_valid, o_last, busy, o_data} !== exp_vec()) begin
                bad++;
                $display("FAIL basic n=%0d got=%h exp=%h", n, {o_valid, o_last, busy, o_data}, exp_vec());
            end
            if (o_valid) nv++;
            drive('0, '0, 1'b1);
        end
        total++;
        if (nv !== 10) begin
            bad++;
            $display("FAIL basic_count got=%0d exp=10", nv);
        end
    endtask

    task automatic test_stall();
        int nv = 0;
        drive('1, frame(16'h0100), 1'b1);
        for (int n = 1; n <= 13; n++) begin
            total++;
            if ({o_valid, o_last, busy, o_data} !== exp_vec()) begin
                bad++;
                $display("FAIL stall n=%0d got=%h exp=%h", n, {o_valid, o_last, busy, o_data}, exp_vec());
            end
            if (o_valid) nv++;
            drive('0, '0, !(n == 3 || n == 4));
        end
        total++;
        if (nv !== 12) begin
            bad++;
            $display("FAIL stall_count got=%0d exp=12", nv);
        end
    endtask

    task automatic test_ignore();
        int nv = 0;
        drive('1, frame(16'h0100), 1'b1);
        for (int n = 1; n <= 11; n++) begin
            total++;
            if ({o_valid, o_last, busy, o_data} !== exp_vec()) begin
                bad++;
                $display("FAIL ignore n=%0d got=%h exp=%h", n, {o_valid, o_last, busy, o_data}, exp_vec());
            end
            if (o_valid) nv++;
            drive((n == 6) ? '1 : '0, (n == 6) ? frame(16'h0300) : '0, 1'b1);
        end
        total++;
        if (nv !== 10) begin
            bad++;
            $display("FAIL ignore_count got=%0d exp=10", nv);
        end
`ifdef LAYER_SER_OVERRUN_DET_EN
        total++;
        if (overrun !== exp_ovr) begin
            bad++;
            $display("FAIL ignore_overrun got=%b exp=%b", overrun, exp_ovr);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        drive('1, frame(16'h0100), 1'b1);
        for (int n = 1; n <= 21; n++) begin
            total++;
            if ({o_valid, o_last, busy, o_data} !== exp_vec()) begin
                bad++;
                $display("FAIL b2b n=%0d got=%h exp=%h", n, {o_valid, o_last, busy, o_data}, exp_vec());
            end
            if (o_valid) nv++;
            drive((n == 10) ? '1 : '0, (n == 10) ? frame(16'h0200) : '0, 1'b1);
        end
        total++;
        if (nv !== 20) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=20", nv);
        end
    endtask

    task automatic test_async_reset();
        drive('1, frame(16'h0100), 1'b1);
        for (int n = 1; n <= 5; n++) begin
            total++;
            if ({o_valid, o_last, busy, o_data} !== exp_vec()) begin
                bad++;
                $display("FAIL areset_pre n=%0d got=%h exp=%h", n, {o_valid, o_last, busy, o_data}, exp_vec());
            end
            if (n < 5) drive('0, '0, 1'b1);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({o_valid, o_last, busy, o_data} !== '0) begin
            bad++;
            $display("FAIL areset_immediate got=%h exp=0", {o_valid, o_last, busy, o_data});
        end
        q.delete();
        exp_ovr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            total++;
            if ({o_valid, o_last, busy, o_data} !== exp_vec()) begin
                bad++;
                $display("FAIL areset_quiet n=%0d got=%h exp=%h", n, {o_valid, o_last, busy, o_data}, exp_vec());
            end
            drive('0, frame(16'h0500), 1'b1);
        end
`ifdef LAYER_SER_OVERRUN_DET_EN
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL areset_overrun got=%b exp=0", overrun);
        end
`endif
        drive('1, frame(16'h0400), 1'b1);
        for (int n = 1; n <= 11; n++) begin
            total++;
            if ({o_valid, o_last, busy, o_data} !== exp_vec()) begin
                bad++;
                $display("FAIL areset_new n=%0d got=%h exp=%h", n, {o_valid, o_last, busy, o_data}, exp_vec());
            end
            drive('0, '0, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [NN-1:0]    iv;
        logic [NN*DW-1:0] d;
        for (int n = 0; n < 400; n++) begin
            total++;
            if ({o_valid, o_last, busy, o_data} !== exp_vec()) begin
                bad++;
                $display("FAIL random n=%0d got=%h exp=%h", n, {o_valid, o_last, busy, o_data}, exp_vec());
            end
`ifdef LAYER_SER_OVERRUN_DET_EN
            total++;
            if (overrun !== exp_ovr) begin
                bad++;
                $display("FAIL random_overrun n=%0d got=%b exp=%b", n, overrun, exp_ovr);
            end
`endif
            iv = NN'($urandom);
            iv[0] = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < NN; k++) d[k*DW +: DW] = DW'($urandom);
            drive(iv, d, $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ignore();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
